// File: rtl/apb_requester.sv
// APB4 requester: converts single-beat valid/ready requests into APB setup/access
// transfers and returns read data, slave error or timeout on a valid/ready response port.
module apb_requester #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [3:0]            req_wstrb_i,

    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  resp_timeout_o,

    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic                  apb_pwrite_o,
    output logic [ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [DATA_WIDTH-1:0] apb_pwdata_o,
    output logic [3:0]            apb_pstrb_o,
    input  logic                  apb_pready_i,
    input  logic [DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                  apb_pslverr_i
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_requester: only DATA_WIDTH = 32 is supported");
    end

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                  req_ready_q,   req_ready_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic [3:0]            pstrb_q,       pstrb_d;
    logic                  resp_valid_q,  resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q,  resp_rdata_d;
    logic                  resp_err_q,    resp_err_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;

    logic accept;
    logic timeout_hit;

    assign accept      = (state_q == IDLE) && req_valid_i && req_ready_q;
    // A pready arriving on the final allowed cycle takes priority over the abort.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !apb_pready_i
                         && (cnt_q == CNT_LAST);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept)                        state_d = SETUP;
            SETUP:                                     state_d = ACCESS;
            ACCESS: if (apb_pready_i || timeout_hit)   state_d = RESP;
            RESP:   if (resp_ready_i)                  state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // Output logic: all outputs are registered, computed from the upcoming state
    always_comb begin
        req_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);

        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        if (accept) begin
            pwrite_d = req_write_i;
            paddr_d  = req_addr_i;
            pwdata_d = req_write_i ? req_wdata_i : '0;
            pstrb_d  = req_write_i ? req_wstrb_i : '0;
        end else if (!psel_d) begin
            pwrite_d = 1'b0;
            paddr_d  = '0;
            pwdata_d = '0;
            pstrb_d  = '0;
        end

        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        resp_timeout_d = resp_timeout_q;
        if ((state_q == ACCESS) && (state_d == RESP)) begin
            resp_valid_d = 1'b1;
            if (apb_pready_i) begin
                resp_err_d     = apb_pslverr_i;
                resp_timeout_d = 1'b0;
                resp_rdata_d   = (!pwrite_q && !apb_pslverr_i) ? apb_prdata_i : '0;
            end else begin
                resp_err_d     = 1'b1;
                resp_timeout_d = 1'b1;
                resp_rdata_d   = '0;
            end
        end else if (state_d != RESP) begin
            resp_valid_d   = 1'b0;
            resp_rdata_d   = '0;
            resp_err_d     = 1'b0;
            resp_timeout_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ACCESS) && !apb_pready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q    <= 1'b0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            pstrb_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            req_ready_q    <= req_ready_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            pstrb_q        <= pstrb_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
            cnt_q          <= cnt_d;
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_err_o     = resp_err_q;
    assign resp_timeout_o = resp_timeout_q;
    assign apb_psel_o     = psel_q;
    assign apb_penable_o  = penable_q;
    assign apb_pwrite_o   = pwrite_q;
    assign apb_paddr_o    = paddr_q;
    assign apb_pwdata_o   = pwdata_q;
    assign apb_pstrb_o    = pstrb_q;

endmodule
